// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// Frames go out back-to-back while the FIFO holds data; tx idles high.
//
// Write handshake: a byte is accepted on a rising clk edge where
// wr_valid=1 and wr_ready=1. wr_ready is low only when the FIFO is full,
// is decoded from the registered count, and does not rise in a cycle that
// pops (no pass-through). wr_valid with wr_ready=0 is dropped silently.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            push, pop, fifo_empty;
  logic            tx_q, tx_d;
  logic [7:0]      shift_q, shift_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;

  assign fifo_empty = (count_q == '0);
  assign wr_ready   = (count_q != DEPTH_C);
  assign push       = wr_valid && wr_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign tx         = tx_q;

  // FIFO storage: written only on an accepting edge, so later wr_data changes are ignored.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // State and serialiser registers; reset forces tx high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles; STOP chains straight into START when data waits.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-exact frame vectors, FIFO corner sequences,
// a frame-decoding monitor scored against an expected-byte queue, and a
// second instance at the full-rate divider.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CPB_L = 87;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [7:0] wr_data_l;
  logic       wr_valid_l;
  logic       wr_ready_l;
  logic       tx_l;
  logic       busy_l;
  logic [$clog2(DEPTH):0] fifo_count_l;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_L), .FIFO_DEPTH(DEPTH)) u_dut_l (
    .clk(clk), .rst(rst), .wr_data(wr_data_l), .wr_valid(wr_valid_l),
    .wr_ready(wr_ready_l), .tx(tx_l), .busy(busy_l), .fifo_count(fifo_count_l)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wr(input logic [7:0] d, input bit accept);
    wr_data  = d;
    wr_valid = 1'b1;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = 8'($urandom_range(0, 255));
  endtask

  // Called on the first cycle of a start bit; checks every cycle of the frame.
  task automatic check_frame(input logic [9:0] frame);
    for (int c = 0; c < 10 * CPB; c++) begin
      chk("frame_bit", tx, frame[9 - c / CPB]);
      chk("frame_busy", busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // ---------------- monitor: decodes frames, compares with exp_q ----------------
  initial begin : monitor
    logic [9:0] fb;
    logic [7:0] e;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        aborted = 1'b0;
        fb = '0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) fb[c / CPB] = tx;
        end
        if (!aborted) begin
          chk("mon_start", fb[0], 1'b0);
          chk("mon_stop", fb[9], 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got byte %0h expected none", fb[8:1]);
          end else begin
            e = exp_q.pop_front();
            chk("mon_byte", fb[8:1], e);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // time order from bit 9: start, d0..d7, stop
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [9:0] fb;
    int n;

    vecs[0] = '{data: 8'hA5, frame: 10'b0101001011};
    vecs[1] = '{data: 8'h3C, frame: 10'b0001111001};
    vecs[2] = '{data: 8'h81, frame: 10'b0100000011};
    vecs[3] = '{data: 8'h5A, frame: 10'b0010110101};

    rst        = 1'b1;
    wr_data    = 8'h00;
    wr_valid   = 1'b0;
    wr_data_l  = 8'h00;
    wr_valid_l = 1'b0;

    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames from idle, cycle exact.
    for (int i = 0; i < 4; i++) begin
      wr(vecs[i].data, 1'b1);
      chk("lat_tx_high", tx, 1'b1);
      chk("lat_count", fifo_count, 1);
      chk("lat_busy", busy, 1'b1);
      @(negedge clk);
      check_frame(vecs[i].frame);
      chk("end_busy", busy, 1'b0);
      chk("end_tx", tx, 1'b1);
      chk("end_count", fifo_count, 0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: no idle gap between frames.
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    chk("b2b_count", fifo_count, 1);
    check_frame(10'b0000000001);
    check_frame(10'b0111111111);
    chk("b2b_busy", busy, 1'b0);
    repeat (3) @(negedge clk);

    // Overflow and no pass-through while full.
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    wr(8'h44, 1'b1);
    wr(8'h55, 1'b1);
    chk("full_count", fifo_count, 4);
    chk("full_ready", wr_ready, 1'b0);
    wr(8'h66, 1'b0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_ready", wr_ready, 1'b0);
    repeat (35) @(negedge clk);
    chk("pre_pop_ready", wr_ready, 1'b0);
    wr(8'h77, 1'b0);
    chk("nopass_count", fifo_count, 3);
    chk("nopass_ready", wr_ready, 1'b1);
    chk("nopass_tx", tx, 1'b0);
    wait_idle(400);
    repeat (3) @(negedge clk);

    // Push on the STOP-final edge while two bytes are queued.
    wr(8'hA1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hC3, 1'b1);
    chk("pp_count_pre", fifo_count, 2);
    repeat (38) @(negedge clk);
    chk("pp_count_late", fifo_count, 2);
    wr(8'hD4, 1'b1);
    chk("pp_count_post", fifo_count, 2);
    chk("pp_tx_start", tx, 1'b0);
    wait_idle(400);
    repeat (3) @(negedge clk);

    // Reset during a start bit: tx must rise without a clock edge.
    wr(8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst1_pre_tx", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst1_tx", tx, 1'b1);
    chk("rst1_busy", busy, 1'b0);
    chk("rst1_count", fifo_count, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    wr(8'h3C, 1'b1);
    wr(8'h99, 1'b1);
    wr(8'h77, 1'b1);
    repeat (16) @(negedge clk);
    chk("rst2_pre_tx", tx, 1'b1);
    chk("rst2_pre_count", fifo_count, 2);
    rst = 1'b1;
    #1;
    chk("rst2_tx", tx, 1'b1);
    chk("rst2_count", fifo_count, 0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_ready", wr_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr(8'h81, 1'b1);
    @(negedge clk);
    check_frame(10'b0100000011);
    chk("post_rst_busy", busy, 1'b0);

    // Full-rate divider: decode 0x5A at mid-bit, check exact frame length.
    wr_data_l  = 8'h5A;
    wr_valid_l = 1'b1;
    @(negedge clk);
    wr_valid_l = 1'b0;
    wr_data_l  = 8'h00;
    n = 0;
    while (tx_l !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("l_fall", tx_l, 1'b0);
    repeat (CPB_L / 2) @(negedge clk);
    fb[0] = tx_l;
    for (int k = 1; k < 10; k++) begin
      repeat (CPB_L) @(negedge clk);
      fb[k] = tx_l;
    end
    chk("l_start", fb[0], 1'b0);
    chk("l_byte", fb[8:1], 8'h5A);
    chk("l_stop", fb[9], 1'b1);
    repeat (CPB_L - CPB_L / 2 - 1) @(negedge clk);
    chk("l_busy_last", busy_l, 1'b1);
    @(negedge clk);
    chk("l_busy_done", busy_l, 1'b0);

    wait_idle(400);
    repeat (2) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
